// File: rtl/reg_access_sequencer_pkg.sv
// Shared types for the register-access sequencer: request opcodes, FSM states
// and the pointer-skip decision used for both shadow pointers.
package reg_seq_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_MOVE  = 2'b01,
        OP_READ  = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SET_PTR = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_SAMPLE  = 3'd3,
        ST_RESP    = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

    // A pointer step is required unless skipping is enabled and the shadow is known to match.
    function automatic logic ptr_needed(input logic skip, input logic ok,
                                        input logic [2:0] shadow, input logic [2:0] target);
        return !skip || !ok || (shadow != target);
    endfunction

endpackage

// File: rtl/reg_access_sequencer_if.sv
// Request/response handshake plus register-file control bus of the sequencer.
// Handshake: a request transfers on a rising clock edge where req_valid and req_ready are both 1;
// rsp_valid and err are single-cycle pulses with no back-pressure.
interface reg_access_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [2:0] req_reg;
    logic [2:0] req_rt;
    logic [7:0] req_data;

    logic       REGWRITE;
    logic       SETSRC;
    logic       SETDEST;
    logic       MOV;
    logic [2:0] rt_index;
    logic [7:0] write_value;
    logic [7:0] rs;
    logic [7:0] rt;

    logic       rsp_valid;
    logic [7:0] rsp_rs;
    logic [7:0] rsp_rt;
    logic       err;

    modport slave (
        input  req_valid, req_op, req_reg, req_rt, req_data, rs, rt,
        output req_ready, REGWRITE, SETSRC, SETDEST, MOV, rt_index, write_value,
               rsp_valid, rsp_rs, rsp_rt, err
    );

    modport master (
        output req_valid, req_op, req_reg, req_rt, req_data, rs, rt,
        input  req_ready, REGWRITE, SETSRC, SETDEST, MOV, rt_index, write_value,
               rsp_valid, rsp_rs, rsp_rt, err
    );
endinterface

// File: rtl/reg_access_sequencer.sv
// Sequences WRITE/MOVE/READ requests into register-file strobes, tracking the
// file's source/destination pointers in shadow registers to skip redundant pointer steps.
module reg_access_sequencer
    import reg_seq_pkg::*;
#(
    parameter bit SKIP_REDUNDANT = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    reg_access_sequencer_if.slave bus,
    output state_t                fsm_state
);

    state_t     state;
    state_t     next_state;
    op_t        lat_op;
    logic [2:0] lat_reg;
    logic [2:0] lat_rt;
    logic [7:0] lat_data;

    logic       dest_ok;
    logic [2:0] dest_shadow;
    logic       src_ok;
    logic [2:0] src_shadow;
    logic [7:0] rsp_rs_q;
    logic [7:0] rsp_rt_q;

    logic       accept;
    logic       regwrite;
    logic       setsrc;
    logic       setdest;
    logic       mov;
    logic [2:0] index;
    logic [7:0] wvalue;
    logic       rsp_pulse;
    logic       err_pulse;

    assign accept = (state == ST_IDLE) && bus.req_valid;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            lat_op      <= OP_WRITE;
            lat_reg     <= 3'd0;
            lat_rt      <= 3'd0;
            lat_data    <= 8'd0;
            dest_ok     <= 1'b0;
            dest_shadow <= 3'd0;
            src_ok      <= 1'b0;
            src_shadow  <= 3'd0;
            rsp_rs_q    <= 8'd0;
            rsp_rt_q    <= 8'd0;
        end else begin
            state <= next_state;
            if (accept) begin
                lat_op   <= op_t'(bus.req_op);
                lat_reg  <= bus.req_reg;
                lat_rt   <= bus.req_rt;
                lat_data <= bus.req_data;
            end
            // Shadows follow the strobes actually issued, so they mirror the register file.
            if (setdest) begin
                dest_shadow <= index;
                dest_ok     <= 1'b1;
            end
            if (setsrc) begin
                src_shadow <= index;
                src_ok     <= 1'b1;
            end
            if (state == ST_SAMPLE) begin
                rsp_rs_q <= bus.rs;
                rsp_rt_q <= bus.rt;
            end
        end
    end

    always_comb begin
        next_state = state;
        regwrite   = 1'b0;
        setsrc     = 1'b0;
        setdest    = 1'b0;
        mov        = 1'b0;
        index      = 3'd0;
        wvalue     = 8'd0;
        rsp_pulse  = 1'b0;
        err_pulse  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    unique case (op_t'(bus.req_op))
                        OP_WRITE: next_state = ptr_needed(SKIP_REDUNDANT, dest_ok, dest_shadow, bus.req_reg)
                                               ? ST_SET_PTR : ST_ACCESS;
                        OP_MOVE:  next_state = ST_ACCESS;
                        OP_READ:  next_state = ptr_needed(SKIP_REDUNDANT, src_ok, src_shadow, bus.req_reg)
                                               ? ST_SET_PTR : ST_SAMPLE;
                        OP_RSVD:  next_state = ST_ERR;
                    endcase
                end
            end
            ST_SET_PTR: begin
                index = lat_reg;
                if (lat_op == OP_WRITE) begin
                    setdest    = 1'b1;
                    next_state = ST_ACCESS;
                end else begin
                    setsrc     = 1'b1;
                    next_state = ST_SAMPLE;
                end
            end
            ST_ACCESS: begin
                regwrite   = 1'b1;
                mov        = (lat_op == OP_MOVE);
                wvalue     = lat_data;
                next_state = ST_IDLE;
            end
            ST_SAMPLE: begin
                index      = lat_rt;
                next_state = ST_RESP;
            end
            ST_RESP: begin
                rsp_pulse  = 1'b1;
                next_state = ST_IDLE;
            end
            ST_ERR: begin
                err_pulse  = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign bus.req_ready   = (state == ST_IDLE);
    assign bus.REGWRITE    = regwrite;
    assign bus.SETSRC      = setsrc;
    assign bus.SETDEST     = setdest;
    assign bus.MOV         = mov;
    assign bus.rt_index    = index;
    assign bus.write_value = wvalue;
    assign bus.rsp_valid   = rsp_pulse;
    assign bus.rsp_rs      = rsp_rs_q;
    assign bus.rsp_rt      = rsp_rt_q;
    assign bus.err         = err_pulse;
    assign fsm_state       = state;

endmodule

// File: tb/tb_reg_access_sequencer.sv
// Bench for reg_access_sequencer: behavioural register file on the control bus,
// per-request strobe traces, and a queue of expected READ responses.
module tb_reg_access_sequencer;
    import reg_seq_pkg::*;

    localparam logic [3:0] S_NONE = 4'b0000;
    localparam logic [3:0] S_RW   = 4'b1000;
    localparam logic [3:0] S_SS   = 4'b0100;
    localparam logic [3:0] S_SD   = 4'b0010;
    localparam logic [3:0] S_MV   = 4'b1001;

    logic   CLK = 1'b0;
    logic   RST_N = 1'b0;
    state_t fsm_state;

    reg_access_sequencer_if bus ();

    reg_access_sequencer #(.SKIP_REDUNDANT(1'b1)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    always #5 CLK = ~CLK;

    // Register file driven by the strobes; pointers survive the sequencer's reset.
    logic [7:0] rf[8] = '{default: 8'h00};
    logic [2:0] rf_dest = 3'd0;
    logic [2:0] rf_src = 3'd0;

    always @(posedge CLK) begin
        if (bus.SETDEST) rf_dest <= bus.rt_index;
        if (bus.SETSRC) rf_src <= bus.rt_index;
        if (bus.REGWRITE) begin
            if (bus.MOV) rf[7] <= bus.write_value;
            else rf[rf_dest] <= bus.write_value;
        end
    end

    assign bus.rs = rf[rf_src];
    assign bus.rt = rf[bus.rt_index];

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_regwrite = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  exp_regs[8] = '{default: 8'h00};

    int          tr_len;
    logic [3:0]  tr_strb[16];
    logic [2:0]  tr_idx[16];
    logic [7:0]  tr_wv[16];
    logic        tr_rsp[16];
    logic        tr_err[16];

    // Advance to the next falling edge and run the every-cycle checks there.
    task automatic tick();
        logic [3:0]  s;
        logic [15:0] e;
        @(negedge CLK);
        s = {bus.REGWRITE, bus.SETSRC, bus.SETDEST, bus.MOV};
        if (bus.REGWRITE) n_regwrite++;
        n_checks++;
        if (!(s == S_NONE || s == S_RW || s == S_SS || s == S_SD || s == S_MV)) begin
            n_errors++;
            $display("FAIL strobe_onehot: got %b expected one of 0000/1000/0100/0010/1001", s);
        end
        if (bus.rsp_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL rsp_unexpected: got rs=%h rt=%h expected no response", bus.rsp_rs, bus.rsp_rt);
            end else begin
                e = exp_q.pop_front();
                if ({bus.rsp_rs, bus.rsp_rt} !== e) begin
                    n_errors++;
                    $display("FAIL rsp_data: got %h expected %h", {bus.rsp_rs, bus.rsp_rt}, e);
                end
            end
        end
    endtask

    task automatic apply_reset();
        RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
        tick();
    endtask

    // Offer one request, scramble the inputs after acceptance, and trace until IDLE.
    task automatic issue(input logic [1:0] op, input logic [2:0] r, input logic [2:0] rt_i,
                         input logic [7:0] d);
        int w = 0;
        while (!bus.req_ready && w < 20) begin
            tick();
            w++;
        end
        n_checks++;
        if (!bus.req_ready) begin
            n_errors++;
            $display("FAIL ready_timeout: got req_ready=0 expected 1");
        end
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_reg   = r;
        bus.req_rt    = rt_i;
        bus.req_data  = d;
        if (op == 2'b00) exp_regs[r] = d;
        if (op == 2'b01) exp_regs[7] = d;
        if (op == 2'b10) exp_q.push_back({exp_regs[r], exp_regs[rt_i]});
        @(posedge CLK);
        #1;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'($urandom_range(0, 3));
        bus.req_reg   = 3'($urandom_range(0, 7));
        bus.req_rt    = 3'($urandom_range(0, 7));
        bus.req_data  = 8'($urandom_range(0, 255));
        tr_len = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.req_ready) break;
            tr_strb[tr_len] = {bus.REGWRITE, bus.SETSRC, bus.SETDEST, bus.MOV};
            tr_idx[tr_len]  = bus.rt_index;
            tr_wv[tr_len]   = bus.write_value;
            tr_rsp[tr_len]  = bus.rsp_valid;
            tr_err[tr_len]  = bus.err;
            tr_len++;
            if (tr_len == 12) begin
                n_checks++;
                n_errors++;
                $display("FAIL op_timeout: got no return to IDLE expected within 11 cycles");
            end
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks += 9;
        if (fsm_state !== ST_IDLE) begin n_errors++; $display("FAIL rst_state: got %0d expected 0", fsm_state); end
        if ({bus.REGWRITE, bus.SETSRC, bus.SETDEST, bus.MOV} !== 4'b0) begin n_errors++; $display("FAIL rst_strobes: got nonzero expected 0"); end
        if (bus.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL rst_rsp_valid: got %b expected 0", bus.rsp_valid); end
        if (bus.err !== 1'b0) begin n_errors++; $display("FAIL rst_err: got %b expected 0", bus.err); end
        if (bus.rt_index !== 3'd0) begin n_errors++; $display("FAIL rst_rt_index: got %0d expected 0", bus.rt_index); end
        if (bus.write_value !== 8'd0) begin n_errors++; $display("FAIL rst_write_value: got %h expected 00", bus.write_value); end
        if (bus.rsp_rs !== 8'd0) begin n_errors++; $display("FAIL rst_rsp_rs: got %h expected 00", bus.rsp_rs); end
        if (bus.rsp_rt !== 8'd0) begin n_errors++; $display("FAIL rst_rsp_rt: got %h expected 00", bus.rsp_rt); end
        RST_N = 1'b1;
        tick();
        if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready: got %b expected 1", bus.req_ready); end
    endtask

    task automatic test_write_set();
        issue(2'b00, 3'd3, 3'd0, 8'hA5);
        n_checks += 6;
        if (tr_len !== 2) begin n_errors++; $display("FAIL wr_set_len: got %0d expected 2", tr_len); end
        if (tr_strb[0] !== S_SD) begin n_errors++; $display("FAIL wr_set_setdest: got %b expected %b", tr_strb[0], S_SD); end
        if (tr_idx[0] !== 3'd3) begin n_errors++; $display("FAIL wr_set_index: got %0d expected 3", tr_idx[0]); end
        if (tr_strb[1] !== S_RW) begin n_errors++; $display("FAIL wr_set_regwrite: got %b expected %b", tr_strb[1], S_RW); end
        if (tr_wv[1] !== 8'hA5) begin n_errors++; $display("FAIL wr_set_value: got %h expected a5", tr_wv[1]); end
        if (rf[3] !== 8'hA5) begin n_errors++; $display("FAIL wr_set_r3: got %h expected a5", rf[3]); end
    endtask

    task automatic test_write_hit();
        issue(2'b00, 3'd3, 3'd6, 8'h11);
        n_checks += 4;
        if (tr_len !== 1) begin n_errors++; $display("FAIL wr_hit_len: got %0d expected 1", tr_len); end
        if (tr_strb[0] !== S_RW) begin n_errors++; $display("FAIL wr_hit_regwrite: got %b expected %b", tr_strb[0], S_RW); end
        if (tr_wv[0] !== 8'h11) begin n_errors++; $display("FAIL wr_hit_value: got %h expected 11", tr_wv[0]); end
        if (rf[3] !== 8'h11) begin n_errors++; $display("FAIL wr_hit_r3: got %h expected 11", rf[3]); end
    endtask

    task automatic test_move();
        issue(2'b01, 3'd5, 3'd1, 8'h7E);
        n_checks += 4;
        if (tr_len !== 1) begin n_errors++; $display("FAIL mov_len: got %0d expected 1", tr_len); end
        if (tr_strb[0] !== S_MV) begin n_errors++; $display("FAIL mov_strobes: got %b expected %b", tr_strb[0], S_MV); end
        if (tr_wv[0] !== 8'h7E) begin n_errors++; $display("FAIL mov_value: got %h expected 7e", tr_wv[0]); end
        if (rf[7] !== 8'h7E) begin n_errors++; $display("FAIL mov_r7: got %h expected 7e", rf[7]); end
        issue(2'b00, 3'd3, 3'd0, 8'h22);
        n_checks += 3;
        if (tr_len !== 1) begin n_errors++; $display("FAIL mov_wr_len: got %0d expected 1", tr_len); end
        if (tr_strb[0] !== S_RW) begin n_errors++; $display("FAIL mov_wr_strobes: got %b expected %b", tr_strb[0], S_RW); end
        if (rf[3] !== 8'h22) begin n_errors++; $display("FAIL mov_wr_r3: got %h expected 22", rf[3]); end
    endtask

    task automatic test_read();
        issue(2'b00, 3'd2, 3'd0, 8'h40);
        issue(2'b00, 3'd5, 3'd0, 8'h09);
        issue(2'b10, 3'd2, 3'd5, 8'hFF);
        n_checks += 6;
        if (tr_len !== 3) begin n_errors++; $display("FAIL rd_len: got %0d expected 3", tr_len); end
        if (tr_strb[0] !== S_SS) begin n_errors++; $display("FAIL rd_setsrc: got %b expected %b", tr_strb[0], S_SS); end
        if (tr_idx[0] !== 3'd2) begin n_errors++; $display("FAIL rd_src_index: got %0d expected 2", tr_idx[0]); end
        if (tr_strb[1] !== S_NONE) begin n_errors++; $display("FAIL rd_sample_strobes: got %b expected 0000", tr_strb[1]); end
        if (tr_idx[1] !== 3'd5) begin n_errors++; $display("FAIL rd_rt_index: got %0d expected 5", tr_idx[1]); end
        if (tr_rsp[2] !== 1'b1) begin n_errors++; $display("FAIL rd_rsp_valid: got %b expected 1", tr_rsp[2]); end
        issue(2'b10, 3'd2, 3'd3, 8'h00);
        n_checks += 3;
        if (tr_len !== 2) begin n_errors++; $display("FAIL rd_hit_len: got %0d expected 2", tr_len); end
        if (tr_strb[0] !== S_NONE) begin n_errors++; $display("FAIL rd_hit_strobes: got %b expected 0000", tr_strb[0]); end
        if ({bus.rsp_rs, bus.rsp_rt} !== 16'h4022) begin n_errors++; $display("FAIL rd_hold: got %h expected 4022", {bus.rsp_rs, bus.rsp_rt}); end
    endtask

    task automatic test_reset_mid_op();
        int rw_before;
        int w = 0;
        while (!bus.req_ready && w < 20) begin
            tick();
            w++;
        end
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b00;
        bus.req_reg   = 3'd3;
        bus.req_data  = 8'h33;
        @(posedge CLK);
        #1;
        bus.req_valid = 1'b0;
        tick();
        n_checks++;
        if (bus.SETDEST !== 1'b1) begin n_errors++; $display("FAIL mid_setdest: got %b expected 1", bus.SETDEST); end
        rw_before = n_regwrite;
        RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
        tick();
        n_checks++;
        if (bus.req_ready !== 1'b1) begin n_errors++; $display("FAIL mid_ready: got %b expected 1", bus.req_ready); end
        tick();
        tick();
        n_checks += 2;
        if (n_regwrite !== rw_before) begin n_errors++; $display("FAIL mid_no_regwrite: got %0d expected 0", n_regwrite - rw_before); end
        if (rf[3] !== 8'h22) begin n_errors++; $display("FAIL mid_r3_kept: got %h expected 22", rf[3]); end
        issue(2'b00, 3'd3, 3'd0, 8'h44);
        n_checks += 3;
        if (tr_len !== 2) begin n_errors++; $display("FAIL mid_rewr_len: got %0d expected 2", tr_len); end
        if (tr_strb[0] !== S_SD) begin n_errors++; $display("FAIL mid_rewr_setdest: got %b expected %b", tr_strb[0], S_SD); end
        if (rf[3] !== 8'h44) begin n_errors++; $display("FAIL mid_rewr_r3: got %h expected 44", rf[3]); end
    endtask

    task automatic test_reserved();
        issue(2'b11, 3'd1, 3'd2, 8'h5A);
        n_checks += 3;
        if (tr_len !== 1) begin n_errors++; $display("FAIL rsvd_ready_return: got %0d expected 1", tr_len); end
        if (tr_err[0] !== 1'b1) begin n_errors++; $display("FAIL rsvd_err: got %b expected 1", tr_err[0]); end
        if (tr_strb[0] !== S_NONE) begin n_errors++; $display("FAIL rsvd_strobes: got %b expected 0000", tr_strb[0]); end
        issue(2'b00, 3'd3, 3'd0, 8'h55);
        n_checks += 2;
        if (tr_len !== 1) begin n_errors++; $display("FAIL rsvd_shadow_kept: got %0d expected 1", tr_len); end
        if (rf[3] !== 8'h55) begin n_errors++; $display("FAIL rsvd_wr_r3: got %h expected 55", rf[3]); end
    endtask

    task automatic test_back_to_back();
        logic       m_dok = 1'b0;
        logic       m_sok = 1'b0;
        logic [2:0] m_d = 3'd0;
        logic [2:0] m_s = 3'd0;
        logic [1:0] op;
        logic [2:0] r;
        logic [2:0] rt_i;
        logic [7:0] d;
        int         exp_len;
        apply_reset();
        for (int i = 0; i < 24; i++) begin
            op   = 2'($urandom_range(0, 2));
            r    = 3'($urandom_range(0, 7));
            rt_i = 3'($urandom_range(0, 7));
            d    = 8'($urandom_range(0, 255));
            if (op == 2'b00) exp_len = (!m_dok || m_d != r) ? 2 : 1;
            else if (op == 2'b01) exp_len = 1;
            else exp_len = (!m_sok || m_s != r) ? 3 : 2;
            issue(op, r, rt_i, d);
            n_checks += 2;
            if (tr_len !== exp_len) begin n_errors++; $display("FAIL b2b_len op=%0d: got %0d expected %0d", op, tr_len, exp_len); end
            else if (op == 2'b10) begin
                if (tr_rsp[exp_len-1] !== 1'b1) begin n_errors++; $display("FAIL b2b_rsp: got %b expected 1", tr_rsp[exp_len-1]); end
            end else begin
                if (tr_wv[exp_len-1] !== d) begin n_errors++; $display("FAIL b2b_wv: got %h expected %h", tr_wv[exp_len-1], d); end
            end
            if (op == 2'b00) begin m_dok = 1'b1; m_d = r; end
            if (op == 2'b10) begin m_sok = 1'b1; m_s = r; end
        end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (rf[k] !== exp_regs[k]) begin n_errors++; $display("FAIL b2b_regfile r%0d: got %h expected %h", k, rf[k], exp_regs[k]); end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_reg   = 3'd0;
        bus.req_rt    = 3'd0;
        bus.req_data  = 8'd0;
        test_reset();
        test_write_set();
        test_write_hit();
        test_move();
        test_read();
        test_reset_mid_op();
        test_reserved();
        test_back_to_back();
        tick();
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL rsp_missing: got %0d outstanding expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/reg_access_sequencer.md
REG_ACCESS_SEQUENCER -- requirements
Module: reg_access_sequencer

Interface
REQ-001 Parameter SKIP_REDUNDANT, default 1: when 1, the block skips SETSRC/SETDEST if the shadow pointer already matches the target.
REQ-002 CLK  in  1  single clock; all state updates on posedge CLK.
REQ-003 RST_N  in  1  reset; synchronous, active-low.
REQ-004 req_valid  in  1  request offered.
REQ-005 req_ready  out  1  block accepts a request this cycle.
REQ-006 req_op  in  2  request type: 00 WRITE, 01 MOVE (write r7), 10 READ, 11 reserved.
REQ-007 req_reg  in  3  destination register for WRITE; source register for READ.
REQ-008 req_rt  in  3  rt register index for READ.
REQ-009 req_data  in  8  write data for WRITE and MOVE.
REQ-010 REGWRITE, SETSRC, SETDEST, MOV  out  1 each  register-file control strobes.
REQ-011 rt_index  out  3  register-file index / pointer operand.
REQ-012 write_value  out  8  register-file write data.
REQ-013 rs, rt  in  8 each  register-file combinational read data.
REQ-014 rsp_valid  out  1  one-cycle pulse marking READ result valid.
REQ-015 rsp_rs, rsp_rt  out  8 each  captured READ data.
REQ-016 err  out  1  one-cycle pulse on a reserved op.

Function
REQ-017 Handshake: a request is accepted on a rising edge where req_valid=1 and req_ready=1; req_ready SHALL be 1 only in IDLE.
REQ-018 FSM states:
- IDLE
- SET_PTR
- ACCESS
- SAMPLE
- RESP
- ERR
REQ-019 At most one of REGWRITE/SETSRC/SETDEST/MOV SHALL be 1 in any cycle; MOV SHALL be asserted only together with REGWRITE, and this pair is the sole exception.
REQ-020 Shadow state: dest_shadow[2:0] with dest_ok, and src_shadow[2:0] with src_ok, mirror the register-file pointers.
REQ-021 WRITE: if the pointer is needed (!dest_ok, dest_shadow!=req_reg, or SKIP_REDUNDANT=0), go to SET_PTR; there, SETDEST=1 and rt_index=req_reg for one cycle, then set dest_shadow=req_reg and dest_ok=1.
REQ-022 WRITE in ACCESS: REGWRITE=1 and write_value=req_data for one cycle, then return to IDLE.
REQ-023 WRITE latency from acceptance edge: 2 cycles to the REGWRITE cycle when the pointer is set, 1 cycle on a pointer hit.
REQ-024 MOVE: ACCESS directly with REGWRITE=1, MOV=1, write_value=req_data for one cycle; dest_shadow is unchanged.
REQ-025 READ pointer step: SET_PTR uses SETSRC=1 and rt_index=req_reg under the same skip rule with src_shadow/src_ok.
REQ-026 READ sample: in SAMPLE, rt_index=req_rt; rs and rt are registered into rsp_rs/rsp_rt at the end of that cycle.
REQ-027 READ response: RESP asserts rsp_valid=1 for exactly one cycle, then IDLE; rsp_rs/rsp_rt hold until the next READ sample.
REQ-028 Reserved op (11): ERR asserts err=1 for one cycle; no control strobes; shadows unchanged; then IDLE.
REQ-029 Request fields SHALL be latched at acceptance; input changes during an operation are ignored.
REQ-030 Idle outputs: all strobes 0, rt_index=0, write_value=0.

Reset
REQ-031 With RST_N=0 at a rising edge, the next state SHALL be:
- FSM in IDLE
- all strobes 0, rsp_valid=0, err=0
- rt_index=0, write_value=0, rsp_rs=0, rsp_rt=0
- dest_ok=0, src_ok=0
REQ-032 Reset mid-operation SHALL drop the in-flight request with no further strobes; req_ready=1 from the first cycle after reset release.

Structure
REQ-033 A shared package reg_seq_pkg SHALL hold the op enum (WRITE/MOVE/READ/RSVD) and the state enum.
REQ-034 Single module; no sub-module, since the shadow tracker is a few flops.

Verification
REQ-035 After reset, WRITE r3=0xA5: SETDEST with rt_index=3, next cycle REGWRITE with write_value=0xA5; reg-file model r3=0xA5.
REQ-036 WRITE r3=0x11 again (SKIP_REDUNDANT=1): REGWRITE on the cycle after acceptance with no SETDEST; r3=0x11.
REQ-037 MOVE 0x7E, then WRITE r3=0x22: r7=0x7E; the second write has no SETDEST (shadow kept); r3=0x22.
REQ-038 With r2=0x40 and r5=0x09, READ src=2 rt=5: SETSRC (rt_index=2), SAMPLE (rt_index=5), then rsp_valid with rsp_rs=0x40 and rsp_rt=0x09.
REQ-039 Assert RST_N=0 during SET_PTR of a WRITE: no REGWRITE; the next WRITE r3 re-issues SETDEST.
REQ-040 Issue op=11: err pulses once, no strobes, req_ready returns in 2 cycles; across all tests, assert strobe one-hotness every cycle.
